// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and write-arbiter state encoding
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_CNT_W = 7;
  localparam int FIFO_DEPTH = 64;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating priority pick; ports req, ptr in; idx (first set bit scanning from ptr upward, wrapping), found out
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        idx = W'((int'(ptr) + i) % N);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding one FIFO write port; ports clk, rst, req_valid/data/last/ready, fifo_wr_en/din/full/counter, grant_valid/id, beat_cnt
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int BURST_MAX = 4,
  parameter int CNT_W = FIFO_CNT_W,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(BURST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full,
  input  logic [CNT_W-1:0]          fifo_counter,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_id,
  output logic [BW-1:0]             beat_cnt
);
  arb_state_t state, state_n;
  logic [IW-1:0] rr_ptr, pick_idx;
  logic pick_found, xfer, release_g;
  logic unused_cnt;
  assign unused_cnt = ^fifo_counter;
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .idx(pick_idx),
    .found(pick_found)
  );
  // rst masks the handshake so an abandoned burst cannot write in the reset cycle
  always_comb begin
    grant_valid = state == ARB_GRANT;
    req_ready = '0;
    if (grant_valid && !rst && !fifo_full) req_ready[grant_id] = 1'b1;
    xfer = req_valid[grant_id] && req_ready[grant_id];
    fifo_wr_en = xfer;
    fifo_din = xfer ? req_data[grant_id*DATA_W +: DATA_W] : '0;
    release_g = grant_valid && ((xfer && (req_last[grant_id] || beat_cnt == BW'(BURST_MAX - 1)))
                || !req_valid[grant_id]);
    state_n = state == ARB_IDLE ? (pick_found && !fifo_full ? ARB_GRANT : ARB_IDLE)
                                : (release_g ? ARB_IDLE : ARB_GRANT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ARB_IDLE && state_n == ARB_GRANT) grant_id <= pick_idx;
      if (release_g) begin
        beat_cnt <= '0;
        rr_ptr <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end else if (xfer) beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter with directed stimulus and a 64-deep occupancy model
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_last = '0, req_ready;
  logic [31:0] req_data = '0;
  logic fifo_wr_en, fifo_full, grant_valid;
  logic [7:0] fifo_din;
  logic [1:0] grant_id;
  logic [2:0] beat_cnt;
  logic [6:0] occ;
  logic full_force = 1'b0, model_on = 1'b0;
  logic [7:0] cnt = '0;
  int checks = 0, errors = 0, writes = 0, w0;
  typedef struct packed {logic [1:0] id; logic [7:0] d;} exp_t;
  exp_t q[$];

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_counter(occ), .grant_valid(grant_valid), .grant_id(grant_id), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;
  assign fifo_full = full_force | (model_on && occ == 7'(FIFO_DEPTH));
  always @(posedge clk) occ <= rst ? '0 : occ + 7'(fifo_wr_en);

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {4'(i), cnt[3:0]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
    set_data();
  endtask

  task automatic expect_w(int id, logic [7:0] d);
    q.push_back({2'(id), d});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en && fifo_full) chk("wr_while_full", 1, 0);
      if (fifo_wr_en) begin
        writes++;
        if (q.size() == 0) chk("unexpected_write", {grant_id, fifo_din}, 0);
        else begin
          e = q.pop_front();
          chk("write_id_data", {grant_id, fifo_din}, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_grants(int n);
    req_valid = '1;
    for (int g = 0; g < n; g++) begin
      tick();
      chk("burst_gv", grant_valid, 1);
      chk("burst_id", grant_id, g % 4);
      for (int b = 0; b < 4; b++) begin
        chk("burst_beat", beat_cnt, b);
        expect_w(g % 4, {4'(g % 4), cnt[3:0]});
        tick();
      end
      chk("bubble_gv", grant_valid, 0);
    end
  endtask

  task automatic chk_idle(string n);
    chk({n, "_gv"}, grant_valid, 0);
    chk({n, "_wr"}, fifo_wr_en, 0);
    chk({n, "_rdy"}, req_ready, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    // reset with every producer requesting
    req_valid = '1;
    set_data();
    repeat (2) begin
      tick();
      chk_idle("reset");
      chk("reset_id", grant_id, 0);
    end
    rst = 1'b0;
    req_valid = '0;
    // single three-beat packet from producer 1
    req_valid = 4'b0010;
    tick();
    chk("p1_gv", grant_valid, 1);
    chk("p1_id", grant_id, 1);
    for (int b = 1; b <= 3; b++) begin
      req_data[15:8] = 8'(b);
      req_last[1] = b == 3;
      expect_w(1, 8'(b));
      tick();
    end
    req_valid = '0;
    req_last = '0;
    chk("p1_release", grant_valid, 0);
    // scan now starts at producer 2, so 3 wins over 0 and 1
    req_valid = 4'b1011;
    req_last = '1;
    tick();
    chk("scan_from2_id", grant_id, 3);
    expect_w(3, {4'd3, cnt[3:0]});
    tick();
    req_valid = '0;
    req_last = '0;
    chk("p3_release", grant_valid, 0);
    // all producers continuous: 0,1,2,3,0
    do_reset();
    run_grants(5);
    req_valid = '0;
    // stall after two beats
    do_reset();
    req_valid = 4'b0001;
    tick();
    chk("stall_id0", grant_id, 0);
    repeat (2) begin
      expect_w(0, {4'd0, cnt[3:0]});
      tick();
    end
    chk("pre_stall_beat", beat_cnt, 2);
    full_force = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_wr", fifo_wr_en, 0);
      chk("stall_rdy", req_ready, 0);
      chk("stall_gv", grant_valid, 1);
      chk("stall_id", grant_id, 0);
      chk("stall_beat", beat_cnt, 2);
      tick();
    end
    full_force = 1'b0;
    repeat (2) begin
      expect_w(0, {4'd0, cnt[3:0]});
      tick();
    end
    chk("post_stall_release", grant_valid, 0);
    req_valid = '0;
    // fill a 64-deep FIFO model
    do_reset();
    model_on = 1'b1;
    w0 = writes;
    run_grants(16);
    chk("fill_occ", occ, 64);
    chk("fill_writes", writes - w0, 64);
    chk("fill_full", fifo_full, 1);
    repeat (4) begin
      tick();
      chk_idle("full_idle");
    end
    req_valid = '0;
    do_reset();
    model_on = 1'b0;
    // early valid drop by producer 2, then reset mid-burst of producer 3
    req_valid = 4'b1100;
    tick();
    chk("drop_id2", grant_id, 2);
    expect_w(2, {4'd2, cnt[3:0]});
    tick();
    req_valid = 4'b1000;
    tick();
    chk("drop_bubble", grant_valid, 0);
    tick();
    chk("drop_next_gv", grant_valid, 1);
    chk("drop_next_id", grant_id, 3);
    expect_w(3, {4'd3, cnt[3:0]});
    tick();
    chk("mid_beat", beat_cnt, 1);
    rst = 1'b1;
    #3;
    chk("rst_cycle_wr", fifo_wr_en, 0);
    tick();
    chk_idle("mid_rst");
    chk("mid_rst_id", grant_id, 0);
    chk("mid_rst_beat", beat_cnt, 0);
    chk("mid_rst_din", fifo_din, 0);
    rst = 1'b0;
    req_valid = '0;
    tick();
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one synchronous byte FIFO (8-bit data, full/empty flags, 7-bit occupancy counter) among NUM_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst, drives the FIFO wr_en/data, and never writes while the FIFO is full. It sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_W, 8, data width, equal to FIFO buf_in width
BURST_MAX, 4, max beats per grant before forced release (>=1)
CNT_W, 7, width of FIFO occupancy counter input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
req_valid  in  NUM_REQ  per-producer data valid
req_data  in  NUM_REQ*DATA_W  producer data; producer i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  final beat of the producer's packet
req_ready  out  NUM_REQ  per-producer accept
fifo_wr_en  out  1  FIFO write enable
fifo_din  out  DATA_W  FIFO write data
fifo_full  in  1  FIFO full flag
fifo_counter  in  CNT_W  FIFO occupancy, status only
grant_valid  out  1  a producer currently holds the grant
grant_id  out  clog2(NUM_REQ)  index of the current grant owner
beat_cnt  out  clog2(BURST_MAX+1)  beats transferred in the current grant

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active high.
- Reset values:
  - state IDLE; rr_ptr 0; grant_valid 0; grant_id 0; beat_cnt 0.
  - req_ready all 0; fifo_wr_en 0; fifo_din 0.
- Reset asserted mid-burst: the burst is abandoned. The arbiter returns to IDLE on the next edge and no write occurs in the reset cycle.
- State IDLE:
  - If any req_valid is set and fifo_full=0, pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register that index as owner and move to GRANT. Arbitration latency is 1 cycle.
  - If fifo_full=1, no grant is issued and the arbiter stays in IDLE.
  - req_ready is all 0 in IDLE.
- State GRANT:
  - req_ready[owner] = !fifo_full (combinational). All other ready bits are 0.
  - A transfer occurs when req_valid[owner] && req_ready[owner].
  - On a transfer: fifo_wr_en=1, fifo_din=req_data[owner], same cycle (combinational, zero latency), and beat_cnt increments.
  - Release (next state IDLE, rr_ptr <= owner+1 mod NUM_REQ, beat_cnt <= 0) happens on any of:
    - a transfer with req_last[owner]=1;
    - a transfer that makes beat_cnt reach BURST_MAX;
    - req_valid[owner]=0 with no transfer in that cycle.
  - fifo_full=1 while in GRANT: stall. No write, the grant is held and beat_cnt is unchanged. A stall does not count as a release.
- Between grants there is exactly one bubble cycle (IDLE), even if a request is pending.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Invariant: fifo_wr_en && fifo_full is never true.
- fifo_counter is not used in grant decisions; it is reserved for status/debug.

Decomposition:
- Shared package fifo_pkg holds:
  - constants FIFO_DATA_W=8, FIFO_CNT_W=7, FIFO_DEPTH=64;
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
- One natural sub-module: rr_pick, a combinational priority rotate. Inputs are req vector and rr_ptr; outputs are index and found.

Test Plan:
1. Reset: rst=1 with all req_valid=1 for 2 cycles -> fifo_wr_en=0, req_ready=0000, grant_valid=0, grant_id=0 throughout.
2. Single packet, producer 1 only:
   - Stimulus: data 0x01, 0x02, 0x03, req_last on the 3rd beat.
   - Response: grant_id=1 one cycle after valid, then three consecutive fifo_wr_en pulses with fifo_din 0x01/0x02/0x03.
   - Then grant_valid=0 and the next grant starts the scan from producer 2.
3. All four producers valid continuously, no last, BURST_MAX=4:
   - Grant order 0, 1, 2, 3, 0.
   - Each grant is 4 beats plus 1 bubble cycle, giving 16 writes in 20 cycles.
   - Verify the wrap from 3 to 0.
4. fifo_full high for 3 cycles mid-burst after 2 beats:
   - During the stall: fifo_wr_en=0, req_ready=0, grant_id and beat_cnt=2 held.
   - After the stall: 2 more beats complete, then release.
5. Feed a 64-deep FIFO model from empty with continuous requests:
   - Exactly 64 writes are accepted and fifo_full asserts.
   - No wr_en while full; no new grant issued from IDLE while full.
6. Early valid drop and reset:
   - Producer 2 drops valid after 1 beat -> release; the next cycle is IDLE and producer 3 is granted.
   - rst asserted mid-burst -> all outputs are at reset values on the following cycle.
